load_store_unit: RTL and testbench

Load/store unit for the RV32I core. It sits between the execute stage and the data RAM. It accepts one memory operation at a time from execute, performs byte-lane steering and misalignment checks, and runs a valid/ready handshake to a word-addressed data memory. It returns load data, sign- or zero-extended, to writeback, tagged with the destination register.

---
 rtl/rv32i_pkg.sv | 30 +++
 rtl/lsu_lane_align.sv | 55 +++++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and load/store unit state encoding.
package rv32i_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } lsu_state_t;

  function automatic logic funct3_illegal(input logic store, input logic [2:0] f3);
    if (store) begin
      return f3 > SW;
    end
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores, extraction/extension for loads, and alignment check.
module lsu_lane_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rdata_i[{addr_i, 3'b000} +: 8];
    rhalf = rdata_i[{addr_i[1], 4'b0000} +: 16];
  end

  // funct3[1:0] encodes access size for both loads and stores.
  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    unique case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o       = 4'b0011 << {addr_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_i[0];
      end
      default: begin
        misalign_o = (addr_i != 2'b00);
      end
    endcase
  end

  always_comb begin
    rdata_o = rdata_i;
    unique case (funct3_i)
      LB:      rdata_o = {{24{rbyte[7]}}, rbyte};
      LBU:     rdata_o = {24'h0, rbyte};
      LH:      rdata_o = {{16{rhalf[15]}}, rhalf};
      LHU:     rdata_o = {16'h0, rhalf};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one operation at a time, valid/ready to word-addressed data RAM.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned MEM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [4:0]        resp_rd,
  output logic [31:0]       resp_data,
  output logic              resp_fault,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state_q, state_d;
  logic [MEM_AW+1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              store_q, store_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       data_q, data_d;
  logic              fault_q, fault_d;

  logic [2:0]  lane_funct3;
  logic [1:0]  lane_addr;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        lane_misalign;
  logic        req_fault;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

  // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
  always_comb begin
    lane_funct3 = (state_q == StIdle) ? req_funct3 : funct3_q;
    lane_addr   = (state_q == StIdle) ? req_addr[1:0] : addr_q[1:0];
  end

  lsu_lane_align u_lane_align (
    .funct3_i  (lane_funct3),
    .addr_i    (lane_addr),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .rdata_o   (lane_rdata),
    .misalign_o(lane_misalign)
  );

  assign req_fault = lane_misalign | funct3_illegal(req_store, req_funct3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      wdata_q  <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    store_d  = store_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    data_d   = data_q;
    fault_d  = fault_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d   = req_addr[MEM_AW+1:0];
          funct3_d = req_funct3;
          store_d  = req_store;
          wdata_d  = req_wdata;
          rd_d     = (!req_store && !req_fault) ? req_rd : 5'd0;
          data_d   = '0;
          fault_d  = req_fault;
          state_d  = req_fault ? StResp : StIssue;
        end
      end
      StIssue: begin
        if (mem_ready) begin
          state_d = store_q ? StResp : StWait;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          data_d  = lane_rdata;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rd    = '0;
    resp_data  = '0;
    resp_fault = 1'b0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StIssue: begin
        mem_valid = 1'b1;
        mem_we    = store_q;
        mem_be    = store_q ? lane_be : 4'b1111;
        mem_addr  = addr_q[MEM_AW+1:2];
        mem_wdata = store_q ? lane_wdata : 32'h0;
      end
      StWait: ;
      StResp: begin
        resp_valid = 1'b1;
        resp_rd    = rd_q;
        resp_data  = data_q;
        resp_fault = fault_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus stall and reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic        mem_valid, mem_ready, mem_we;
  logic [3:0]  mem_be;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_AW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rd    (req_rd),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rd   (resp_rd),
    .resp_data (resp_data),
    .resp_fault(resp_fault),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [7:0]  maddr;
    logic        fault;
    logic [31:0] data;
    logic [4:0]  rrd;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        fault;
  } resp_t;

  vec_t  vecs[$];
  resp_t sb[$];
  int    n_pass = 0;
  int    n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [4:0] rd,
                              input logic [31:0] rdata, input logic [3:0] be,
                              input logic [31:0] mwd, input logic [7:0] maddr,
                              input logic fault, input logic [31:0] data,
                              input logic [4:0] rrd);
    vec_t v;
    v.store = st; v.f3 = f3; v.addr = addr; v.wdata = wd; v.rd = rd; v.rdata = rdata;
    v.be = be; v.mwdata = mwd; v.maddr = maddr; v.fault = fault; v.data = data; v.rrd = rrd;
    return v;
  endfunction

  task automatic run_op(input vec_t v, input int rdy_dly, input int rv_dly, input int rsp_dly);
    resp_t e, got;
    @(negedge clk);
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_store = v.store; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    @(posedge clk);
    e.rd = v.rrd; e.data = v.data; e.fault = v.fault;
    sb.push_back(e);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_funct3 = 3'($urandom); req_rd = 5'($urandom); req_store = 1'($urandom);
    @(negedge clk);
    if (!v.fault) begin
      for (int i = 0; i <= rdy_dly; i++) begin
        check("issue_valid", {31'h0, mem_valid}, 32'h1);
        check("issue_we", {31'h0, mem_we}, {31'h0, v.store});
        check("issue_be", {28'h0, mem_be}, {28'h0, v.be});
        check("issue_addr", {24'h0, mem_addr}, {24'h0, v.maddr});
        if (v.store) check("issue_wdata", mem_wdata, v.mwdata);
        check("issue_req_ready", {31'h0, req_ready}, 32'h0);
        if (i == rdy_dly) mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        @(negedge clk);
      end
      if (!v.store) begin
        for (int i = 0; i <= rv_dly; i++) begin
          check("wait_quiet", {30'h0, mem_valid, resp_valid}, 32'h0);
          check("wait_req_ready", {31'h0, req_ready}, 32'h0);
          if (i == rv_dly) begin
            mem_rvalid = 1'b1; mem_rdata = v.rdata;
          end
          @(posedge clk); #1 mem_rvalid = 1'b0; mem_rdata = $urandom;
          @(negedge clk);
        end
      end
    end else begin
      check("fault_no_mem", {31'h0, mem_valid}, 32'h0);
    end
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    got = sb.pop_front();
    for (int i = 0; i <= rsp_dly; i++) begin
      check("resp_valid", {31'h0, resp_valid}, 32'h1);
      check("resp_rd", {27'h0, resp_rd}, {27'h0, got.rd});
      check("resp_data", resp_data, got.data);
      check("resp_fault", {31'h0, resp_fault}, {31'h0, got.fault});
      check("resp_req_ready", {31'h0, req_ready}, 32'h0);
      check("resp_no_mem", {31'h0, mem_valid}, 32'h0);
      if (i == rsp_dly) resp_ready = 1'b1;
      @(posedge clk); #1 resp_ready = 1'b0;
      @(negedge clk);
    end
    check("post_req_ready", {31'h0, req_ready}, 32'h1);
    check("post_resp_valid", {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; req_rd = '0; resp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0;

    //           st  f3      addr          wdata         rd     rdata         be       mwdata        maddr  flt  data          rrd
    vecs.push_back(mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd5, 32'h0, 4'b1111, 32'hDEADBEEF, 8'h04, 0, 32'h0, 5'd0));
    vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 5'd7, 32'hDEADBEEF, 4'b1111, 32'h0, 8'h04, 0, 32'hDEADBEEF, 5'd7));
    vecs.push_back(mk(1, 3'b000, 32'h13, 32'h000000F0, 5'd1, 32'h0, 4'b1000, 32'hF0F0F0F0, 8'h04, 0, 32'h0, 5'd0));
    vecs.push_back(mk(0, 3'b000, 32'h13, 32'h0, 5'd3, 32'hF0000000, 4'b1111, 32'h0, 8'h04, 0, 32'hFFFFFFF0, 5'd3));
    vecs.push_back(mk(0, 3'b100, 32'h13, 32'h0, 5'd4, 32'hF0000000, 4'b1111, 32'h0, 8'h04, 0, 32'h000000F0, 5'd4));
    vecs.push_back(mk(1, 3'b001, 32'h22, 32'h1234ABCD, 5'd2, 32'h0, 4'b1100, 32'hABCDABCD, 8'h08, 0, 32'h0, 5'd0));
    vecs.push_back(mk(0, 3'b001, 32'h22, 32'h0, 5'd9, 32'h80010000, 4'b1111, 32'h0, 8'h08, 0, 32'hFFFF8001, 5'd9));
    vecs.push_back(mk(0, 3'b101, 32'h22, 32'h0, 5'd10, 32'h80010000, 4'b1111, 32'h0, 8'h08, 0, 32'h00008001, 5'd10));
    vecs.push_back(mk(0, 3'b000, 32'h01, 32'h0, 5'd11, 32'h00007F00, 4'b1111, 32'h0, 8'h00, 0, 32'h0000007F, 5'd11));
    vecs.push_back(mk(0, 3'b010, 32'hFFFFFC04, 32'h0, 5'd31, 32'h13572468, 4'b1111, 32'h0, 8'h01, 0, 32'h13572468, 5'd31));
    vecs.push_back(mk(1, 3'b000, 32'h21, 32'h5A5A5A3C, 5'd6, 32'h0, 4'b0010, 32'h3C3C3C3C, 8'h08, 0, 32'h0, 5'd0));
    vecs.push_back(mk(0, 3'b001, 32'h01, 32'h0, 5'd12, 32'h0, 4'b0, 32'h0, 8'h0, 1, 32'h0, 5'd0));
    vecs.push_back(mk(1, 3'b010, 32'h06, 32'h12345678, 5'd13, 32'h0, 4'b0, 32'h0, 8'h0, 1, 32'h0, 5'd0));
    vecs.push_back(mk(0, 3'b011, 32'h00, 32'h0, 5'd14, 32'h0, 4'b0, 32'h0, 8'h0, 1, 32'h0, 5'd0));
    vecs.push_back(mk(1, 3'b100, 32'h00, 32'h0, 5'd15, 32'h0, 4'b0, 32'h0, 8'h0, 1, 32'h0, 5'd0));
    vecs.push_back(mk(0, 3'b010, 32'h02, 32'h0, 5'd16, 32'h0, 4'b0, 32'h0, 8'h0, 1, 32'h0, 5'd0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_flags", {28'h0, resp_valid, resp_fault, mem_valid, mem_we}, 32'h0);
    check("rst_mem_be_addr", {20'h0, mem_be, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_resp", {resp_rd, resp_data[26:0]}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], 0, 0, 0);

    // Stalls on every handshake.
    run_op(vecs[1], 3, 2, 2);
    run_op(vecs[5], 2, 0, 1);
    run_op(vecs[11], 0, 0, 3);

    // Reset while waiting for read data; the late rvalid must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; req_rd = 5'd2;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_seq_issue", {31'h0, mem_valid}, 32'h1);
    mem_ready = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0;
    @(negedge clk);
    check("rst_seq_wait", {30'h0, mem_valid, req_ready}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rst_seq_idle", {29'h0, req_ready, resp_valid, mem_valid}, 32'h4);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(negedge clk);
    check("rst_seq_stray", {29'h0, req_ready, resp_valid, mem_valid}, 32'h4);
    check("rst_seq_data", resp_data, 32'h0);
    run_op(vecs[3], 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1);
  end

endmodule
